// File: rtl/wildcat_loader_pkg.sv
// Shared definitions for the Wildcat UART boot loader: sync byte,
// loader and receiver state encodings, and the baud divider helper.
package wildcat_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_WAIT_SYNC,
    ST_GET_COUNT,
    ST_GET_DATA,
    ST_DONE
  } loader_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // Clock cycles per UART bit.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/wildcat_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling baud counter,
// LSB-first shift register. Emits a one-cycle byte_valid for a good stop bit
// and a one-cycle frame_err for a bad one, then waits for an idle line.
module wildcat_uart_rx
  import wildcat_loader_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output rx_state_e  dbg_state
);

  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);

  logic            rx_meta;
  logic            rx_sync;
  rx_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  assign dbg_state = state;

  // Bring the asynchronous pin into the clock domain; idle level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Bit-level receive FSM; samples land mid-bit, DIV/2 after the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line that is high again at mid-start-bit was only a glitch.
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_W'(DIV - 1)) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CNT_W'(DIV - 1)) begin
            cnt <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
              state      <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wildcat_uart_loader.sv
// Serial boot loader: frames UART bytes (A5, N, 4*N data bytes) into
// little-endian 32-bit words, writes them to instruction memory and holds
// the core in reset until all N words are accepted.
// Write port handshake: a word transfers on a rising edge where wr_valid and
// wr_ready are both high; once wr_valid rises it stays high with wr_addr and
// wr_data unchanged until that transfer, unless the load is aborted.
module wildcat_uart_loader
  import wildcat_loader_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_rst_n,
  output logic              loading,
  output logic              err,
  output loader_state_e     dbg_state,
  output rx_state_e         dbg_rx_state
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_err;
  loader_state_e state;
  logic [7:0]    load_left;    // words still to assemble from the stream
  logic [7:0]    accept_left;  // words still to be accepted by memory
  logic [1:0]    byte_idx;
  logic [23:0]   shift;

  logic              accept;
  logic              word_done;
  logic              overflow;
  logic              wrap;
  logic              addr_carry;
  logic [ADDR_W-1:0] addr_next;

  assign dbg_state = state;

  wildcat_uart_rx #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err),
    .dbg_state  (dbg_rx_state)
  );

  // Handshake and error conditions evaluated against the current cycle.
  always_comb begin
    accept                  = wr_valid && wr_ready;
    {addr_carry, addr_next} = {1'b0, wr_addr} + (ADDR_W + 1)'(4);
    word_done               = byte_valid && (byte_idx == 2'd3) && (load_left != 8'd0);
    overflow                = word_done && wr_valid && !wr_ready;
    wrap                    = accept && addr_carry && (accept_left != 8'd1);
  end

  // Frame-level loader FSM with registered write port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT_SYNC;
      load_left   <= '0;
      accept_left <= '0;
      byte_idx    <= '0;
      shift       <= '0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      core_rst_n  <= 1'b0;
      loading     <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        ST_WAIT_SYNC, ST_DONE: begin
          // Framing errors are ignored here; only a sync byte matters.
          if (byte_valid && byte_data == SYNC_BYTE) begin
            state      <= ST_GET_COUNT;
            loading    <= 1'b1;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
            wr_addr    <= '0;
            wr_valid   <= 1'b0;
          end
        end
        ST_GET_COUNT: begin
          if (frame_err || (byte_valid && byte_data == 8'd0)) begin
            state      <= ST_WAIT_SYNC;
            wr_valid   <= 1'b0;
            loading    <= 1'b0;
            core_rst_n <= 1'b0;
            err        <= 1'b1;
          end else if (byte_valid) begin
            load_left   <= byte_data;
            accept_left <= byte_data;
            byte_idx    <= '0;
            state       <= ST_GET_DATA;
          end
        end
        ST_GET_DATA: begin
          if (frame_err || overflow || wrap) begin
            state      <= ST_WAIT_SYNC;
            wr_valid   <= 1'b0;
            loading    <= 1'b0;
            core_rst_n <= 1'b0;
            err        <= 1'b1;
          end else begin
            if (accept) begin
              wr_valid    <= 1'b0;
              wr_addr     <= addr_next;
              accept_left <= accept_left - 8'd1;
              if (accept_left == 8'd1) begin
                state      <= ST_DONE;
                core_rst_n <= 1'b1;
                loading    <= 1'b0;
              end
            end
            // A new word may be presented on the same edge the old one leaves.
            if (byte_valid && load_left != 8'd0) begin
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                wr_data   <= {byte_data, shift};
                wr_valid  <= 1'b1;
                load_left <= load_left - 8'd1;
              end else begin
                shift <= {byte_data, shift[23:8]};
              end
            end
          end
        end
        default: state <= ST_WAIT_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_wildcat_uart_loader.sv
// Bench for wildcat_uart_loader: UART byte driver, memory-side ready driver,
// write scoreboard fed by a byte-stream model, directed and random frames.
module tb_wildcat_uart_loader;
  import wildcat_loader_pkg::*;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int ADDR_W   = 10;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int W        = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx = 1'b1;
  logic              wr_ready = 1'b1;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_rst_n;
  logic              loading;
  logic              err;
  loader_state_e     dbg_state;
  rx_state_e         dbg_rx_state;

  int n_cmp = 0;
  int n_err = 0;
  int ready_mode = 0;  // 0: always ready, 1: ready after 50 valid cycles, 2: never ready

  logic [W-1:0] exp_q[$];
  logic [7:0]   frame_q[$];

  wildcat_uart_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .core_rst_n   (core_rst_n),
    .loading      (loading),
    .err          (err),
    .dbg_state    (dbg_state),
    .dbg_rx_state (dbg_rx_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory-side ready driver
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: wr_ready = 1'b1;
        2: wr_ready = 1'b0;
        default: begin
          if (wr_valid) begin
            wait_cnt++;
            wr_ready = (wait_cnt >= 50);
          end else begin
            wait_cnt = 0;
            wr_ready = 1'b0;
          end
        end
      endcase
    end
  end

  // Scoreboard monitor: checks every accepted write and pending-word stability
  initial begin
    logic              prev_pend;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;
    logic [W-1:0]      exp;
    prev_pend = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pend = 1'b0;
      end else begin
        if (prev_pend && err === 1'b0) begin
          check("hold wr_valid", wr_valid, 1);
          check("hold wr_addr", wr_addr, prev_addr);
          check("hold wr_data", wr_data, prev_data);
        end
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected write: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
          end else begin
            exp = exp_q.pop_front();
            check("write addr", wr_addr, exp[W-1:32]);
            check("write data", wr_data, exp[31:0]);
          end
        end
        prev_pend = wr_valid && !wr_ready;
        prev_addr = wr_addr;
        prev_data = wr_data;
      end
    end
  end

  // Driver tasks
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    drive_bit(1'b1);
  endtask

  // Send frame_q[lo..hi]; the byte at index bad gets a zero stop bit.
  task automatic send_range(input int lo, input int hi, input int bad);
    for (int i = lo; i <= hi; i++) send_byte(frame_q[i], i != bad);
  endtask

  task automatic frame_set(input logic [7:0] a[], input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(a[i]);
  endtask

  // Reference model: parse the byte stream as the frame protocol describes
  // and queue every word the memory should receive.
  task automatic model_frame(input int bad, output logic exp_err);
    int st;  // 0 hunting for sync, 1 expecting count, 2 data, 3 loaded
    int n;
    int k;
    logic [31:0] word;
    st = 0; n = 0; k = 0; word = '0; exp_err = 1'b0;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == bad) begin
        if (st == 1 || st == 2) exp_err = 1'b1;
        break;
      end
      case (st)
        0, 3: if (frame_q[i] == 8'hA5) begin st = 1; exp_err = 1'b0; end
        1: begin
          if (frame_q[i] == 8'h00) begin exp_err = 1'b1; st = 0; end
          else begin n = frame_q[i]; k = 0; word = '0; st = 2; end
        end
        default: begin
          word = word | (32'(frame_q[i]) << (8 * (k % 4)));
          k++;
          if (k % 4 == 0) begin
            exp_q.push_back({ADDR_W'((k / 4 - 1) * 4), word});
            word = '0;
          end
          if (k == 4 * n) st = 3;
        end
      endcase
    end
  endtask

  task automatic wait_load(input string name);
    int t;
    t = 0;
    while (core_rst_n !== 1'b1 && t < 400) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check({name, " core_rst_n"}, core_rst_n, 1);
    check({name, " err"}, err, 0);
    check({name, " loading"}, loading, 0);
    check({name, " state"}, dbg_state, ST_DONE);
    check({name, " pending writes"}, exp_q.size(), 0);
  endtask

  task automatic check_abort(input string name);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check({name, " err"}, err, 1);
    check({name, " wr_valid"}, wr_valid, 0);
    check({name, " state"}, dbg_state, ST_WAIT_SYNC);
    check({name, " core_rst_n"}, core_rst_n, 0);
    check({name, " loading"}, loading, 0);
    check({name, " pending writes"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, " wr_valid"}, wr_valid, 0);
    check({name, " wr_addr"}, wr_addr, 0);
    check({name, " wr_data"}, wr_data, 0);
    check({name, " core_rst_n"}, core_rst_n, 0);
    check({name, " loading"}, loading, 0);
    check({name, " err"}, err, 0);
    check({name, " state"}, dbg_state, ST_WAIT_SYNC);
    check({name, " rx state"}, dbg_rx_state, RX_IDLE);
  endtask

  // Stimulus and final report
  initial begin
    logic exp_err;
    logic [7:0] b;
    int nw;
    int nj;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Two-word frame, memory always ready
    ready_mode = 0;
    frame_set('{8'hA5, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 10);
    exp_q.push_back({10'h000, 32'h12345678});
    exp_q.push_back({10'h004, 32'hDEADBEEF});
    send_range(0, 0, -1);
    @(negedge clk);
    check("after sync loading", loading, 1);
    check("after sync state", dbg_state, ST_GET_COUNT);
    check("after sync core_rst_n", core_rst_n, 0);
    send_range(1, 9, -1);
    wait_load("ready frame");

    // Same frame, memory stalls 50 cycles per word
    ready_mode = 1;
    exp_q.push_back({10'h000, 32'h12345678});
    exp_q.push_back({10'h004, 32'hDEADBEEF});
    send_range(0, 9, -1);
    wait_load("stalled frame");

    // Memory never ready: second word overflows
    ready_mode = 2;
    send_range(0, 9, -1);
    check_abort("overflow");
    ready_mode = 0;
    repeat (5) @(posedge clk); #1;

    // Junk before sync, single word
    frame_set('{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00}, 9);
    exp_q.push_back({10'h000, 32'h00000001});
    send_range(0, 8, -1);
    wait_load("junk prefix");

    // Framing error on third data byte, then a clean frame
    frame_set('{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44}, 6);
    send_range(0, 4, 4);
    check_abort("framing error");
    frame_set('{8'hA5, 8'h01, 8'hC3, 8'hB2, 8'hA1, 8'h90}, 6);
    exp_q.push_back({10'h000, 32'h90A1B2C3});
    send_range(0, 5, -1);
    wait_load("after framing error");

    // Zero word count
    frame_set('{8'hA5, 8'h00}, 2);
    send_range(0, 1, -1);
    check_abort("zero count");

    // Short low glitch in the middle of a word
    frame_set('{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}, 6);
    exp_q.push_back({10'h000, 32'h44332211});
    send_range(0, 3, -1);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * DIV) @(posedge clk); #1;
    send_range(4, 5, -1);
    wait_load("glitch");

    // Random frames against the model
    for (int it = 0; it < 6; it++) begin
      ready_mode = $urandom_range(0, 1);
      frame_q.delete();
      nj = $urandom_range(0, 3);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        frame_q.push_back(b);
      end
      nw = $urandom_range(1, 5);
      frame_q.push_back(8'hA5);
      frame_q.push_back(8'(nw));
      for (int j = 0; j < 4 * nw; j++) frame_q.push_back(8'($urandom_range(0, 255)));
      model_frame(-1, exp_err);
      send_range(0, frame_q.size() - 1, -1);
      wait_load("random frame");
      check("random model err", err, exp_err);
    end

    // Reset in the middle of a byte with a word pending
    ready_mode = 2;
    frame_set('{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 7);
    send_range(0, 6, -1);
    @(negedge clk);
    check("mid-frame wr_valid", wr_valid, 1);
    rx = 1'b0;
    repeat (25) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("mid-frame reset");
    rx = 1'b1;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3 * DIV) @(posedge clk); #1;
    frame_set('{8'hA5, 8'h01, 8'h0D, 8'hF0, 8'hAD, 8'h8B}, 6);
    exp_q.push_back({10'h000, 32'h8BADF00D});
    send_range(0, 5, -1);
    wait_load("after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wildcat_uart_loader.md
# wildcat_uart_loader

Serial boot loader in front of the Wildcat core: receives an 8N1 UART byte stream on a dedicated input pin, frames it into 32-bit little-endian words and writes them into instruction memory through a valid/ready port. Holds the core in reset while loading and releases it once the announced number of words has been written. Sits between the `ui_in` RX pin and the core/memory inside `tt_um_schoeberl_wildcat`.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115_200: UART bit rate; `DIV = CLK_FREQ/BAUD` (integer, ≥ 4).
- `ADDR_W`, 10: byte address width of the write port.

- `clk`  in  1  system clock, all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  UART serial input, idle high, asynchronous to `clk`.
- `wr_valid`  out  1  write request to instruction memory.
- `wr_ready`  in  1  memory accepts write when high together with `wr_valid`.
- `wr_addr`  out  ADDR_W  byte address of word, 0, 4, 8, ...
- `wr_data`  out  32  word, first received byte in bits 7:0.
- `core_rst_n`  out  1  reset to core, low while not loaded or loading.
- `loading`  out  1  high from sync byte until last word accepted.
- `err`  out  1  sticky error flag, cleared by next sync byte.

## Operation
- RX: `rx` through 2-FF synchronizer. Falling edge in idle starts bit counter; re-sample at DIV/2: low → valid start, high → false start, back to idle. Then sample data bits 0..7 (LSB first) and stop bit every DIV cycles. Stop = 1 → one-cycle `byte_valid` with `byte_data`; stop = 0 → framing error pulse, no byte; RX waits for `rx` high before re-arming.
- Frame: `0xA5`, count byte N (words, 1..255), then 4·N data bytes.
- FSM states: WAIT_SYNC → (byte 0xA5) GET_COUNT → (N≠0) GET_DATA → (N-th word accepted) DONE.
  - WAIT_SYNC: non-0xA5 bytes ignored.
  - GET_COUNT: N = 0 → set `err`, WAIT_SYNC.
  - GET_DATA: bytes shift into word register; 4th byte loads `wr_data`, asserts `wr_valid`. Handshake completes on `wr_valid && wr_ready`; `wr_addr` += 4 after each accepted word.
  - DONE: `core_rst_n` = 1. Byte 0xA5 restarts load (core_rst_n → 0, address → 0); other bytes ignored.
- Errors (set `err`, abort to WAIT_SYNC, drop `wr_valid`, `loading` = 0, `core_rst_n` stays 0): framing error while not in WAIT_SYNC/DONE; 4th byte of next word completes while previous word still pending (overflow); address wrap past 2^ADDR_W.
- Framing error in WAIT_SYNC or DONE: ignored, no flag.
- `wr_valid` once high stays high with stable `wr_addr`/`wr_data` until accepted.

## Timing
- Reset values: `wr_valid` 0, `wr_addr` 0, `wr_data` 0, `core_rst_n` 0, `loading` 0, `err` 0; RX idle, FSM WAIT_SYNC. Reset mid-byte or mid-frame discards all partial state.
- Synchronizer latency 2 cycles; stop bit sampled 9.5·DIV cycles after detected falling edge (+2 sync).
- `byte_valid` → FSM update next edge; `wr_valid` high 1 cycle after 4th `byte_valid`.
- `loading` high 1 cycle after sync byte's `byte_valid`; `core_rst_n` high and `loading` low the cycle after the last handshake.
- Handshake with `wr_ready` held high: `wr_valid` is a single-cycle pulse.

## Structure
- Package `wildcat_loader_pkg`: `SYNC_BYTE = 8'hA5`, FSM state enum, DIV computation function.
- Sub-module `wildcat_uart_rx` (synchronizer, baud counter, shift register, byte_valid/frame_err); loader FSM and write port in top.

## Test plan (CLK_FREQ=1_000_000, BAUD=100_000, DIV=10)
- Frame A5 02 78 56 34 12 EF BE AD DE, `wr_ready`=1 → writes (0x000,0x12345678), (0x004,0xDEADBEEF); `core_rst_n` rises after 2nd; `err`=0.
- Same frame, `wr_ready` low 50 cycles per word → `wr_valid`/addr/data stable until ready; result identical, no overflow.
- `wr_ready`=0 through 8 data bytes → `err`=1, `wr_valid` 0, FSM WAIT_SYNC, `core_rst_n` 0.
- Bytes 00 FF 13 then A5 01 01 00 00 00 → junk ignored; single write (0x000,0x00000001).
- Stop bit forced 0 on 3rd data byte → `err`=1, no write; following valid frame clears `err` and loads.
- 3-cycle low glitch on `rx` → no byte; `rst_n` low mid-frame → all outputs back to reset values.
